// File: rtl/eth_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_pkg
// Description : Shared types and constants for the Ethernet TX arbiter.
//               Holds the arbiter state type, the grant encodings and a helper
//               that maps a state onto its grant vector.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_tx_pkg;

   // Grant states share their low bits with the grant vector, so GRANT_A/
   // GRANT_D read out directly as GNT_A/GNT_D. GAP must still report no grant.
   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GRANT_A = 2'b01,
      GRANT_D = 2'b10,
      GAP     = 2'b11
   } arb_state_t;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_A    = 2'b01;
   localparam logic [1:0] GNT_D    = 2'b10;

   function automatic logic [1:0] grant_of(input arb_state_t state);
      case (state)
         GRANT_A: grant_of = GNT_A;
         GRANT_D: grant_of = GNT_D;
         default: grant_of = GNT_NONE;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/eth_tx_arbiter_frame_counter.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_arbiter_frame_counter
// Description : Wrapping frame counter with a single-cycle increment strobe.
// Ports       : clk    - clock
//               rst_n  - asynchronous active-low reset (clears the count)
//               inc    - increment strobe, one count per cycle it is high
//               count  - current count, wraps from all-ones to zero
// Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_arbiter_frame_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (inc) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_arbiter
// Description : Frame-level arbiter sharing one TX stream between the ARP
//               reply source (A) and the data/IP source (D). ARP wins ties
//               unless it has taken ARP_BURST_MAX grants in a row while D was
//               waiting. A grant lasts a whole frame; IFG_CYCLES idle cycles
//               follow every frame. Per-source completed-frame counters.
// Ports       : clk, rst_n            - clock, async active-low reset
//               i_enable              - allow new grants (never cuts a frame)
//               a_data/valid/last/ready - ARP reply stream
//               d_data/valid/last/ready - data-path stream
//               o_tx_data/valid/last, o_tx_ready - muxed stream to the MAC
//               o_busy                - arbiter not idle
//               o_grant               - {grant_d, grant_a}
//               o_arp_frames/o_data_frames - completed frame counts (wrap)
// Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_arbiter
   import eth_tx_pkg::*;
#(
   parameter int DATA_W        = 32,
   parameter int ARP_BURST_MAX = 4,
   parameter int IFG_CYCLES    = 3,
   parameter int CNT_W         = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_enable,
   input  logic [DATA_W-1:0] a_data,
   input  logic              a_valid,
   input  logic              a_last,
   output logic              a_ready,
   input  logic [DATA_W-1:0] d_data,
   input  logic              d_valid,
   input  logic              d_last,
   output logic              d_ready,
   output logic [DATA_W-1:0] o_tx_data,
   output logic              o_tx_valid,
   output logic              o_tx_last,
   input  logic              o_tx_ready,
   output logic              o_busy,
   output logic [1:0]        o_grant,
   output logic [CNT_W-1:0]  o_arp_frames,
   output logic [CNT_W-1:0]  o_data_frames
);

   localparam int c_starve_w = $clog2(ARP_BURST_MAX + 1);
   localparam int c_gap_w    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
   localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(ARP_BURST_MAX);
   localparam logic [c_gap_w-1:0]    c_gap_load   =
      c_gap_w'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

   arb_state_t            r_state;
   arb_state_t            w_next_state;
   logic [c_gap_w-1:0]    r_gap_cnt;
   logic [c_starve_w-1:0] r_starve_cnt;
   logic [c_starve_w-1:0] w_starve_inc;
   logic [1:0]            r_grant;
   logic                  w_starved;
   logic                  w_frame_end;
   logic                  w_a_done;
   logic                  w_d_done;

   // D has waited through a full ARP burst and is still asking.
   assign w_starved    = d_valid && (r_starve_cnt == c_starve_max);
   assign w_starve_inc = (r_starve_cnt == c_starve_max) ? r_starve_cnt
                                                        : r_starve_cnt + 1'b1;

   assign w_frame_end = o_tx_valid && o_tx_ready && o_tx_last;
   assign w_a_done    = (r_state == GRANT_A) && w_frame_end;
   assign w_d_done    = (r_state == GRANT_D) && w_frame_end;

   // ------------------------------------------------------------------
   // State register plus the small counters that move with it
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_grant      <= GNT_NONE;
         r_gap_cnt    <= '0;
         r_starve_cnt <= '0;
      end else begin
         r_state <= w_next_state;
         r_grant <= grant_of(w_next_state);

         // The starvation count only moves on an IDLE decision; it looks at
         // d_valid as seen at that decision.
         if (r_state == IDLE) begin
            if (w_next_state == GRANT_A) begin
               r_starve_cnt <= d_valid ? w_starve_inc : '0;
            end else if (w_next_state == GRANT_D) begin
               r_starve_cnt <= '0;
            end
         end

         if ((r_state != GAP) && (w_next_state == GAP)) begin
            r_gap_cnt <= c_gap_load;
         end else if ((r_state == GAP) && (r_gap_cnt != '0)) begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (i_enable) begin
               if (a_valid && !w_starved) begin
                  w_next_state = GRANT_A;
               end else if (d_valid) begin
                  w_next_state = GRANT_D;
               end
            end
         end
         GRANT_A, GRANT_D: begin
            if (w_frame_end) begin
               w_next_state = (IFG_CYCLES > 0) ? GAP : IDLE;
            end
         end
         GAP: begin
            if (r_gap_cnt == '0) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Output logic: zero-latency mux while granted, everything 0 otherwise
   // ------------------------------------------------------------------
   always_comb begin
      o_tx_data  = '0;
      o_tx_valid = 1'b0;
      o_tx_last  = 1'b0;
      a_ready    = 1'b0;
      d_ready    = 1'b0;
      case (r_state)
         GRANT_A: begin
            o_tx_data  = a_data;
            o_tx_valid = a_valid;
            o_tx_last  = a_last;
            a_ready    = o_tx_ready;
         end
         GRANT_D: begin
            o_tx_data  = d_data;
            o_tx_valid = d_valid;
            o_tx_last  = d_last;
            d_ready    = o_tx_ready;
         end
         default: begin
            o_tx_data  = '0;
         end
      endcase
   end

   assign o_busy  = (r_state != IDLE);
   assign o_grant = r_grant;

   eth_tx_arbiter_frame_counter #(
      .CNT_W (CNT_W)
   ) u_arp_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_a_done),
      .count (o_arp_frames)
   );

   eth_tx_arbiter_frame_counter #(
      .CNT_W (CNT_W)
   ) u_data_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_d_done),
      .count (o_data_frames)
   );

endmodule
`default_nettype wire
